matrix_operand_loader: RTL and testbench

Stream-to-array front end for the matrix multiplier. It accepts matrix elements one at a time over a valid/ready stream, A first and then B, both row-major. It assembles the elements into the flat operand arrays, then pulses valid_o for one cycle so the multiplier latches a full operand set. It sits between a host/DMA element stream and the multiplier's a_i/b_i/valid_i inputs.

---
 rtl/matrix_pkg.sv | 23 ++
 rtl/matrix_operand_loader.sv | 136 +++++++++++++
 tb/tb_matrix_operand_loader.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix multiplier front end: default matrix
// geometry, the operand loader state encoding and an element-count helper.
package matrix_pkg;

  localparam int unsigned DEF_DATA_WIDTH       = 8;
  localparam int unsigned DEF_A_ROWS           = 8;
  localparam int unsigned DEF_B_COLUMNS        = 5;
  localparam int unsigned DEF_A_COLUMNS_B_ROWS = 4;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    ISSUE  = 2'd2,
    ERROR  = 2'd3
  } loader_state_e;

  // Number of elements in a rows x cols matrix.
  function automatic int unsigned mat_size(input int unsigned rows,
                                           input int unsigned cols);
    return rows * cols;
  endfunction

endpackage

// File: rtl/matrix_operand_loader.sv
// Stream-to-array front end for the matrix multiplier.
// Collects A (row-major) then B (row-major) elements from a valid/ready
// stream into flat registered arrays and pulses valid_o for one cycle when
// a complete, correctly framed operand set is held. A misplaced or missing
// s_last_i pulses error_o instead and the set is discarded.
//
// Ports:
//   clk_i      clock, rising edge
//   reset_i    synchronous active-high reset
//   s_valid_i  element stream valid
//   s_ready_o  element stream ready (low during reset, ISSUE and ERROR)
//   s_data_i   element value
//   s_last_i   marks the final element of B
//   valid_o    one-cycle pulse, a_o/b_o hold a complete operand set
//   a_o        A elements, index i*A_COLUMNS_B_ROWS+k
//   b_o        B elements, index k*B_COLUMNS+j
//   error_o    one-cycle pulse, framing error
module matrix_operand_loader
  import matrix_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int unsigned A_ROWS           = DEF_A_ROWS,
  parameter int unsigned B_COLUMNS        = DEF_B_COLUMNS,
  parameter int unsigned A_COLUMNS_B_ROWS = DEF_A_COLUMNS_B_ROWS
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_last_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] a_o [A_ROWS*A_COLUMNS_B_ROWS],
  output logic [DATA_WIDTH-1:0] b_o [A_COLUMNS_B_ROWS*B_COLUMNS],
  output logic                  error_o
);

  localparam int unsigned A_SIZE   = mat_size(A_ROWS, A_COLUMNS_B_ROWS);
  localparam int unsigned B_SIZE   = mat_size(A_COLUMNS_B_ROWS, B_COLUMNS);
  localparam int unsigned MAX_SIZE = (A_SIZE > B_SIZE) ? A_SIZE : B_SIZE;
  localparam int unsigned CNT_W    = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1;

  loader_state_e         state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  s_ready_q, s_ready_d;
  logic                  valid_q, valid_d;
  logic                  error_q, error_d;
  logic [DATA_WIDTH-1:0] a_q [A_SIZE];
  logic [DATA_WIDTH-1:0] a_d [A_SIZE];
  logic [DATA_WIDTH-1:0] b_q [B_SIZE];
  logic [DATA_WIDTH-1:0] b_d [B_SIZE];
  logic                  xfer;

  assign xfer = s_valid_i && s_ready_q;

  // State, counter, operand arrays and registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= LOAD_A;
      cnt_q     <= '0;
      s_ready_q <= 1'b0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      a_q       <= '{default: '0};
      b_q       <= '{default: '0};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s_ready_q <= s_ready_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      a_q       <= a_d;
      b_q       <= b_d;
    end
  end

  // Next state, element capture and counter update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;

    unique case (state_q)
      LOAD_A: begin
        if (xfer) begin
          a_d[cnt_q] = s_data_i;
          if (s_last_i) begin
            // last can never legally fall inside A
            state_d = ERROR;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(A_SIZE - 1)) begin
            state_d = LOAD_B;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      LOAD_B: begin
        if (xfer) begin
          b_d[cnt_q] = s_data_i;
          if (cnt_q == CNT_W'(B_SIZE - 1)) begin
            state_d = s_last_i ? ISSUE : ERROR;
            cnt_d   = '0;
          end else if (s_last_i) begin
            state_d = ERROR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ISSUE, ERROR: begin
        state_d = LOAD_A;
        cnt_d   = '0;
      end
      default: begin
        state_d = LOAD_A;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered images of the state being entered.
    s_ready_d = (state_d == LOAD_A) || (state_d == LOAD_B);
    valid_d   = (state_d == ISSUE);
    error_d   = (state_d == ERROR);
  end

  assign s_ready_o = s_ready_q;
  assign valid_o   = valid_q;
  assign error_o   = error_q;
  assign a_o       = a_q;
  assign b_o       = b_q;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed bench for matrix_operand_loader: a table of operand-set scenarios
// plus hand-written reset-mid-load and back-to-back sequences.
module tb_matrix_operand_loader;

  localparam int unsigned A_SIZE = 32;
  localparam int unsigned B_SIZE = 20;
  localparam int unsigned N_EL   = A_SIZE + B_SIZE;

  logic       clk;
  logic       reset_i;
  logic       s_valid_i;
  logic       s_ready_o;
  logic [7:0] s_data_i;
  logic       s_last_i;
  logic       valid_o;
  logic       error_o;
  logic [7:0] a_o [A_SIZE];
  logic [7:0] b_o [B_SIZE];

  matrix_operand_loader dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .s_data_i  (s_data_i),
    .s_last_i  (s_last_i),
    .valid_o   (valid_o),
    .a_o       (a_o),
    .b_o       (b_o),
    .error_o   (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_a [A_SIZE];
  logic [7:0] exp_b [B_SIZE];

  // Pulse monitor, sampled on the falling edge.
  int cyc       = 0;
  int vcnt      = 0;
  int ecnt      = 0;
  int last_v    = 0;
  bit both_seen = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid_o === 1'b1) begin
      vcnt++;
      last_v = cyc;
    end
    if (error_o === 1'b1) ecnt++;
    if (valid_o === 1'b1 && error_o === 1'b1) both_seen = 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_arrays(input string tag);
    int bad_a = 0;
    int bad_b = 0;
    for (int i = 0; i < int'(A_SIZE); i++) if (a_o[i] !== exp_a[i]) bad_a++;
    for (int j = 0; j < int'(B_SIZE); j++) if (b_o[j] !== exp_b[j]) bad_b++;
    chk({tag, "_a_o_bad_elems"}, 64'(bad_a), 64'd0);
    chk({tag, "_b_o_bad_elems"}, 64'(bad_b), 64'd0);
  endtask

  // Drive one element and wait (bounded) for its handshake; updates the model.
  task automatic send_elem(input int idx, input logic [7:0] d, input logic last, input bit gaps);
    bit ok = 1'b0;
    bit hs;
    if (gaps) begin
      for (int g = 0; g < 4; g++) begin
        if ($urandom_range(1, 0) == 0) break;
        s_valid_i = 1'b0;
        @(posedge clk); #1;
      end
    end
    s_valid_i = 1'b1;
    s_data_i  = d;
    s_last_i  = last;
    for (int t = 0; t < 100; t++) begin
      hs = s_ready_o;
      @(posedge clk); #1;
      if (hs) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("handshake_timeout", 64'd1, 64'd0);
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    if (idx < int'(A_SIZE)) exp_a[idx] = d;
    else exp_b[idx - int'(A_SIZE)] = d;
  endtask

  // Stream one operand set; last_idx < 0 means s_last_i never asserted.
  task automatic run_set(input int last_idx, input bit gaps, input bit ff,
                         input bit exp_ok, input string tag);
    int n_send;
    logic [7:0] d;
    vcnt = 0;
    ecnt = 0;
    n_send = (exp_ok || last_idx < 0) ? int'(N_EL) : last_idx + 1;
    for (int e = 0; e < n_send; e++) begin
      if (ff) d = 8'hFF;
      else if (e < int'(A_SIZE)) d = 8'(e + 1);
      else d = 8'(e - int'(A_SIZE) + 1);
      send_elem(e, d, 1'(e == last_idx), gaps);
    end
    // cycle right after the closing handshake
    chk({tag, "_valid"}, 64'(valid_o), 64'(exp_ok));
    chk({tag, "_error"}, 64'(error_o), 64'(!exp_ok));
    chk({tag, "_ready_busy"}, 64'(s_ready_o), 64'd0);
    chk_arrays({tag, "_pulse"});
    @(posedge clk); #1;
    chk({tag, "_valid_after"}, 64'(valid_o), 64'd0);
    chk({tag, "_error_after"}, 64'(error_o), 64'd0);
    chk({tag, "_ready_after"}, 64'(s_ready_o), 64'd1);
    chk_arrays({tag, "_hold"});
    chk({tag, "_valid_pulses"}, 64'(vcnt), 64'(exp_ok));
    chk({tag, "_error_pulses"}, 64'(ecnt), 64'(!exp_ok));
  endtask

  typedef struct {
    int last_idx;
    bit gaps;
    bit ff;
    bit exp_ok;
  } set_vec_t;

  set_vec_t vecs [6];

  initial begin
    int p1;

    vecs[0] = '{last_idx: 51, gaps: 1'b0, ff: 1'b0, exp_ok: 1'b1};
    vecs[1] = '{last_idx: 51, gaps: 1'b1, ff: 1'b0, exp_ok: 1'b1};
    vecs[2] = '{last_idx: 39, gaps: 1'b0, ff: 1'b0, exp_ok: 1'b0};
    vecs[3] = '{last_idx: 51, gaps: 1'b0, ff: 1'b0, exp_ok: 1'b1};
    vecs[4] = '{last_idx: -1, gaps: 1'b0, ff: 1'b0, exp_ok: 1'b0};
    vecs[5] = '{last_idx: 51, gaps: 1'b1, ff: 1'b1, exp_ok: 1'b1};

    for (int i = 0; i < int'(A_SIZE); i++) exp_a[i] = 8'h00;
    for (int j = 0; j < int'(B_SIZE); j++) exp_b[j] = 8'h00;

    reset_i   = 1'b1;
    s_valid_i = 1'b0;
    s_data_i  = 8'h00;
    s_last_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 64'(s_ready_o), 64'd0);
    chk("reset_valid", 64'(valid_o), 64'd0);
    chk("reset_error", 64'(error_o), 64'd0);
    chk_arrays("reset");
    reset_i = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_ready", 64'(s_ready_o), 64'd1);

    // idle holds everything
    repeat (5) @(posedge clk);
    #1;
    chk("idle_valid", 64'(valid_o), 64'd0);
    chk_arrays("idle");

    for (int v = 0; v < 6; v++)
      run_set(vecs[v].last_idx, vecs[v].gaps, vecs[v].ff, vecs[v].exp_ok,
              $sformatf("vec%0d", v));

    // reset after 30 elements discards the partial set
    vcnt = 0;
    ecnt = 0;
    for (int e = 0; e < 30; e++) send_elem(e, 8'(8'h40 + e), 1'b0, 1'b0);
    reset_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midreset_ready", 64'(s_ready_o), 64'd0);
    chk("midreset_valid", 64'(valid_o), 64'd0);
    chk("midreset_error", 64'(error_o), 64'd0);
    for (int i = 0; i < int'(A_SIZE); i++) exp_a[i] = 8'h00;
    for (int j = 0; j < int'(B_SIZE); j++) exp_b[j] = 8'h00;
    chk_arrays("midreset");
    reset_i = 1'b0;
    @(posedge clk); #1;
    chk("midreset_release_ready", 64'(s_ready_o), 64'd1);
    chk("midreset_no_pulses", 64'(vcnt + ecnt), 64'd0);
    run_set(51, 1'b0, 1'b0, 1'b1, "after_reset");

    // back-to-back sets, second all 8'hFF
    run_set(51, 1'b0, 1'b0, 1'b1, "b2b1");
    p1 = last_v;
    run_set(51, 1'b0, 1'b1, 1'b1, "b2b2");
    chk("b2b_pulse_gap", 64'(last_v - p1), 64'(N_EL + 1));

    chk("valid_error_overlap", 64'(both_seen), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
